// File: rtl/mem_access_stage.sv
// MEM stage of the five-stage MIPS core: data memory with byte-lane stores,
// store-data forwarding, sign/zero-extended loads, and the MEM/WB register.
module mem_access_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC3,
  input  logic [31:0] Instr3,
  input  logic [31:0] Result3,
  input  logic [31:0] B3,
  input  logic [4:0]  WA3,
  input  logic [31:0] imm32_3,
  input  logic        ForwardRTM,
  input  logic [31:0] WD,
  output logic [31:0] PC4,
  output logic [31:0] Instr4,
  output logic [31:0] Result4,
  output logic [31:0] DR4,
  output logic [4:0]  WA4,
  output logic [31:0] imm32_4
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0]       mem [DEPTH];
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        off;
  logic [31:0]       store_data;
  logic [31:0]       rd_word;
  logic [15:0]       rd_half;
  logic [7:0]        rd_byte;
  logic [31:0]       load_data;
  logic [3:0]        byte_en;
  logic [31:0]       wr_word;

  assign opcode     = Instr3[31:26];
  assign word_addr  = Result3[ADDR_W+1:2];
  assign off        = Result3[1:0];
  assign store_data = ForwardRTM ? WD : B3;
  assign rd_word    = mem[word_addr];
  assign rd_half    = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (off)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    case (opcode)
      OP_LW:  load_data = rd_word;
      OP_LH:  load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU: load_data = {16'h0, rd_half};
      OP_LB:  load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU: load_data = {24'h0, rd_byte};
      default: load_data = 32'h0;
    endcase
  end

  // Replicate the narrow store data across all lanes; byte_en picks the lanes.
  always_comb begin
    byte_en = 4'b0000;
    wr_word = store_data;
    case (opcode)
      OP_SW: begin
        byte_en = 4'b1111;
        wr_word = store_data;
      end
      OP_SH: begin
        byte_en = off[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{store_data[15:0]}};
      end
      OP_SB: begin
        byte_en = 4'b0001 << off;
        wr_word = {4{store_data[7:0]}};
      end
      default: begin
        byte_en = 4'b0000;
        wr_word = store_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) mem[word_addr][8*l +: 8] <= wr_word[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC4     <= 32'h0;
      Instr4  <= 32'h0;
      Result4 <= 32'h0;
      DR4     <= 32'h0;
      WA4     <= 5'h0;
      imm32_4 <= 32'h0;
    end else begin
      PC4     <= PC3;
      Instr4  <= Instr3;
      Result4 <= Result3;
      DR4     <= load_data;
      WA4     <= WA3;
      imm32_4 <= imm32_3;
    end
  end

endmodule
